// File: rtl/ex2_hilo.sv
// Second execute stage: registers stage-1 results and owns the HI/LO accumulator.
// HI/LO update on the edge where the instruction leaves this stage, so every op applies once.
module ex2_hilo (
  input  logic        Clock,
  input  logic        nReset,
  input  logic        Stall,
  input  logic        Flush,
  input  logic [63:0] In,
  input  logic        RegWriteIn,
  input  logic        MemWriteIn,
  input  logic        ACCEn,
  input  logic [2:0]  HLOp,
  input  logic [4:0]  DestIn,
  input  logic [31:0] MemDataIn,
  output logic [31:0] Out,
  output logic        RegWriteOut,
  output logic        MemWriteOut,
  output logic [4:0]  DestOut,
  output logic [31:0] MemData,
  output logic        Valid,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic [2:0] {
    HL_NONE = 3'b000,
    HL_LOAD = 3'b001,
    HL_MADD = 3'b010,
    HL_MSUB = 3'b011,
    HL_MTHI = 3'b100,
    HL_MTLO = 3'b101,
    HL_MFHI = 3'b110,
    HL_MFLO = 3'b111
  } hl_op_e;

  logic [63:0] in_q, in_d;
  logic        reg_write_q, reg_write_d;
  logic        mem_write_q, mem_write_d;
  logic        acc_en_q, acc_en_d;
  hl_op_e      hl_op_q, hl_op_d;
  logic [4:0]  dest_q, dest_d;
  logic [31:0] mem_data_q, mem_data_d;
  logic        valid_q, valid_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic [63:0] hilo_cur;
  logic        hilo_we;

  assign hilo_cur = {hi_q, lo_q};
  assign hilo_we  = valid_q && acc_en_q && !Stall;

  always_comb begin
    in_d        = in_q;
    reg_write_d = reg_write_q;
    mem_write_d = mem_write_q;
    acc_en_d    = acc_en_q;
    hl_op_d     = hl_op_q;
    dest_d      = dest_q;
    mem_data_d  = mem_data_q;
    valid_d     = valid_q;
    // Flush wins over Stall and inserts an all-zero bubble
    if (Flush) begin
      in_d        = 64'd0;
      reg_write_d = 1'b0;
      mem_write_d = 1'b0;
      acc_en_d    = 1'b0;
      hl_op_d     = HL_NONE;
      dest_d      = 5'd0;
      mem_data_d  = 32'd0;
      valid_d     = 1'b0;
    end else if (!Stall) begin
      in_d        = In;
      reg_write_d = RegWriteIn;
      mem_write_d = MemWriteIn;
      acc_en_d    = ACCEn;
      hl_op_d     = hl_op_e'(HLOp);
      dest_d      = DestIn;
      mem_data_d  = MemDataIn;
      valid_d     = 1'b1;
    end
  end

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (hilo_we) begin
      case (hl_op_q)
        HL_LOAD: {hi_d, lo_d} = in_q;
        HL_MADD: {hi_d, lo_d} = hilo_cur + in_q;
        HL_MSUB: {hi_d, lo_d} = hilo_cur - in_q;
        HL_MTHI: hi_d = in_q[31:0];
        HL_MTLO: lo_d = in_q[31:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (!nReset) begin
      in_q        <= 64'd0;
      reg_write_q <= 1'b0;
      mem_write_q <= 1'b0;
      acc_en_q    <= 1'b0;
      hl_op_q     <= HL_NONE;
      dest_q      <= 5'd0;
      mem_data_q  <= 32'd0;
      valid_q     <= 1'b0;
      hi_q        <= 32'd0;
      lo_q        <= 32'd0;
    end else begin
      in_q        <= in_d;
      reg_write_q <= reg_write_d;
      mem_write_q <= mem_write_d;
      acc_en_q    <= acc_en_d;
      hl_op_q     <= hl_op_d;
      dest_q      <= dest_d;
      mem_data_q  <= mem_data_d;
      valid_q     <= valid_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
    end
  end

  // Moves read the live HI/LO, so they see an accumulate that landed on the same edge
  always_comb begin
    Out = in_q[31:0];
    if (acc_en_q && hl_op_q == HL_MFHI) Out = hi_q;
    else if (acc_en_q && hl_op_q == HL_MFLO) Out = lo_q;
  end

  assign RegWriteOut = reg_write_q;
  assign MemWriteOut = mem_write_q;
  assign DestOut     = dest_q;
  assign MemData     = mem_data_q;
  assign Valid       = valid_q;
  assign HI          = hi_q;
  assign LO          = lo_q;

endmodule
